instr_mem: RTL and testbench

Word-addressed instruction memory that answers the fetch stage's `rom_address`/`rom_data` port and is also the target of the boot-time program loader. It accepts a little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit words and writes them from word 0 upward. While a load is in progress it holds the core off with `busy` and returns NOP to fetch.

---
 rtl/instr_mem.sv | 173 +++++++++++++++++
 tb/tb_instr_mem.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
//
// Word-addressed instruction memory. It serves the fetch stage through a
// synchronous read port. It is also the target of the boot-time program
// loader, which streams a little-endian byte image over a valid/ready
// handshake. The bytes are packed into 32-bit words and written from word 0
// upward. While a load is in progress the core is stalled with `busy`, and
// fetch sees NOP_WORD.
//
// Parameters:
//   DEPTH_LOG2    memory holds 2^DEPTH_LOG2 32-bit words
//   NOP_WORD      value returned while in reset or while busy
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   rom_address   word address from fetch (only [DEPTH_LOG2-1:0] used)
//   rom_data      registered read data, one cycle latency
//   load_valid    loader byte present
//   load_byte     loader data byte
//   load_last     final byte of the image (qualified by load_valid)
//   load_ready    a byte can be accepted this cycle
//   busy          load in progress, core must stall
//   words_loaded  words committed by the current or most recent load
//   ovf           sticky: the image exceeded the memory depth
// ---------------------------------------------------------------------------
module instr_mem #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rom_address,
    output logic [31:0]           rom_data,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   words_loaded,
    output logic                  ovf
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [1:0]            lane;
    logic [31:0]           word_buf;
    logic                  commit_last;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic                  xfer;
    logic                  mem_we;
    logic                  next_busy;
    logic                  unused_addr_hi;

    logic [31:0]           mem [DEPTH];

    assign xfer       = load_valid && load_ready;
    assign busy       = (state != IDLE);
    assign load_ready = (state != COMMIT);

    // The top pointer bit set means the pointer has reached DEPTH.
    // Once that happens, every further word is dropped.
    assign mem_we     = (state == COMMIT) && !wr_ptr[DEPTH_LOG2];

    // Address bits above the memory depth are ignored, so reads wrap.
    assign unused_addr_hi = ^rom_address[31:DEPTH_LOG2];

    // Next-state logic. It is shared by the state register and by the read
    // path, which must know the busy value for the coming cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    next_state = load_last ? COMMIT : LOAD;
                end
            end
            LOAD: begin
                if (xfer && (lane == 2'd3 || load_last)) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = commit_last ? IDLE : LOAD;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign next_busy = (next_state != IDLE);

    // Loader FSM. It handles byte packing, the write pointer and the
    // load statistics. The word buffer is cleared at every commit, so lanes
    // left unfilled by a short final word read back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lane         <= 2'd0;
            word_buf     <= 32'd0;
            commit_last  <= 1'b0;
            wr_ptr       <= '0;
            words_loaded <= '0;
            ovf          <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        words_loaded <= '0;
                        ovf          <= 1'b0;
                        wr_ptr       <= '0;
                        word_buf     <= {24'd0, load_byte};
                        lane         <= 2'd1;
                        commit_last  <= load_last;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        word_buf[{lane, 3'b000} +: 8] <= load_byte;
                        lane                          <= lane + 2'd1;
                        commit_last                   <= load_last;
                    end
                end
                COMMIT: begin
                    if (!wr_ptr[DEPTH_LOG2]) begin
                        wr_ptr       <= wr_ptr + PTR_ONE;
                        words_loaded <= words_loaded + PTR_ONE;
                    end else begin
                        ovf <= 1'b1;
                    end
                    lane     <= 2'd0;
                    word_buf <= 32'd0;
                end
                default: begin
                    lane <= 2'd0;
                end
            endcase
        end
    end

    // Memory array write port. It has no reset, so the contents survive a
    // reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= word_buf;
        end
    end

    // Registered read port. NOP_WORD is returned for any cycle in which the
    // block will be busy, so fetch never sees a half-written image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_data <= NOP_WORD;
        end else if (next_busy) begin
            rom_data <= NOP_WORD;
        end else begin
            rom_data <= mem[rom_address[DEPTH_LOG2-1:0]];
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_mem
//
// Directed testbench for instr_mem. It uses two instances:
//   dut_a  DEPTH_LOG2 = 10  reset, full load, partial word, address wrap,
//                           reset in the middle of a load
//   dut_b  DEPTH_LOG2 = 2   image overflow
// Expectations are queued together with the cycle at which they become due.
// A monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_instr_mem;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;

    logic [31:0] a_addr, a_rom;
    logic        a_valid, a_last, a_ready, a_busy, a_ovf;
    logic [7:0]  a_byte;
    logic [10:0] a_words;

    logic [31:0] b_addr, b_rom;
    logic        b_valid, b_last, b_ready, b_busy, b_ovf;
    logic [7:0]  b_byte;
    logic [2:0]  b_words;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    instr_mem #(.DEPTH_LOG2(10)) dut_a (
        .clk(clk), .rst(rst), .rom_address(a_addr), .rom_data(a_rom),
        .load_valid(a_valid), .load_byte(a_byte), .load_last(a_last),
        .load_ready(a_ready), .busy(a_busy), .words_loaded(a_words), .ovf(a_ovf)
    );

    instr_mem #(.DEPTH_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .rom_address(b_addr), .rom_data(b_rom),
        .load_valid(b_valid), .load_byte(b_byte), .load_last(b_last),
        .load_ready(b_ready), .busy(b_busy), .words_loaded(b_words), .ovf(b_ovf)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Select the observed DUT output: 0-4 for dut_a, 5-9 for dut_b
    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return a_rom;
            1:       return {31'd0, a_busy};
            2:       return {31'd0, a_ready};
            3:       return {21'd0, a_words};
            4:       return {31'd0, a_ovf};
            5:       return b_rom;
            6:       return {31'd0, b_busy};
            7:       return {31'd0, b_ready};
            8:       return {29'd0, b_words};
            default: return {31'd0, b_ovf};
        endcase
    endfunction

    // Single comparison point
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation that has become due
    always @(negedge clk) begin : monitor
        int idx;
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].due <= cyc) begin
                checkOutput(sb[idx].name, observe(sb[idx].sel), sb[idx].exp);
                sb.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    // Queue an expectation d cycles from now (0 = the state after the last edge)
    task automatic expectAt(input int d, input int sel, input logic [31:0] e,
                            input string n);
        exp_t item;
        item.due  = cyc + d;
        item.sel  = sel;
        item.exp  = e;
        item.name = n;
        sb.push_back(item);
    endtask

    // Offer one byte and hold it until accepted, with a bounded wait
    task automatic applyStimulus(input bit inst, input logic [7:0] b, input bit last);
        int waited;
        bit rdy;
        if (!inst) begin
            a_valid = 1'b1; a_byte = b; a_last = last;
        end else begin
            b_valid = 1'b1; b_byte = b; b_last = last;
        end
        waited = 0;
        forever begin
            rdy = inst ? b_ready : a_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL load_accept_timeout: byte %h not accepted, required within 20 cycles", b);
                break;
            end
        end
        if (!inst) begin
            a_valid = 1'b0; a_last = 1'b0;
        end else begin
            b_valid = 1'b0; b_last = 1'b0;
        end
    endtask

    task automatic loadWord(input bit inst, input logic [31:0] w, input bit last);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(inst, w[8*i +: 8], last && (i == 3));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a read. The data is due one edge later.
    task automatic readWord(input bit inst, input logic [31:0] addr,
                            input logic [31:0] e, input string n);
        if (!inst) a_addr = addr;
        else       b_addr = addr;
        expectAt(1, inst ? 5 : 0, e, n);
        idle(1);
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h5A000000 + i * 32'h00000101;
    endfunction

    initial begin
        rst = 1'b1;
        a_addr = 32'd0; a_valid = 1'b1; a_byte = 8'h99; a_last = 1'b0;
        b_addr = 32'd0; b_valid = 1'b1; b_byte = 8'h99; b_last = 1'b0;
        #1 rst = 1'b0;

        // 1. Reset with load_valid high
        idle(1);
        expectAt(0, 0, NOP,   "reset_rom_data");
        expectAt(0, 1, 32'd0, "reset_busy");
        expectAt(0, 2, 32'd1, "reset_load_ready");
        expectAt(0, 3, 32'd0, "reset_words_loaded");
        expectAt(0, 4, 32'd0, "reset_ovf");
        expectAt(0, 6, 32'd0, "reset_b_busy");
        idle(1);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        expectAt(0, 1, 32'd0, "no_accept_in_reset_busy");
        expectAt(0, 3, 32'd0, "no_accept_in_reset_words");

        // 2. Full two-word load, back to back
        applyStimulus(0, 8'h13, 0);
        expectAt(0, 1, 32'd1, "busy_after_first_byte");
        applyStimulus(0, 8'h05, 0);
        applyStimulus(0, 8'h10, 0);
        applyStimulus(0, 8'h00, 0);
        expectAt(0, 2, 32'd0, "ready_low_commit_word0");
        expectAt(0, 1, 32'd1, "busy_in_commit_word0");
        applyStimulus(0, 8'h93, 0);
        applyStimulus(0, 8'h05, 0);
        applyStimulus(0, 8'h20, 0);
        applyStimulus(0, 8'h00, 1);
        expectAt(0, 2, 32'd0, "ready_low_commit_word1");
        idle(1);
        expectAt(0, 1, 32'd0, "busy_after_full_load");
        expectAt(0, 3, 32'd2, "words_after_full_load");
        expectAt(0, 2, 32'd1, "ready_after_full_load");
        readWord(0, 32'd0, 32'h00100513, "read_word0");
        readWord(0, 32'd1, 32'h00200593, "read_word1");

        // 3. Partial final word is zero-padded
        applyStimulus(0, 8'hAA, 0);
        applyStimulus(0, 8'hBB, 1);
        idle(1);
        expectAt(0, 3, 32'd1, "words_after_partial");
        readWord(0, 32'd0, 32'h0000BBAA, "read_partial");
        readWord(0, 32'd1, 32'h00200593, "read_retained_word1");

        // 4. Fill the whole 1024-word array, then check address wrap
        for (int i = 0; i < 1024; i++) begin
            loadWord(0, pat(i), i == 1023);
        end
        idle(1);
        expectAt(0, 3, 32'd1024, "words_full_depth");
        expectAt(0, 4, 32'd0,    "ovf_full_depth");
        readWord(0, 32'h00000400, pat(0),    "wrap_400");
        readWord(0, 32'h000007FF, pat(1023), "wrap_7FF");
        readWord(0, 32'h000003FF, pat(1023), "read_3FF");
        readWord(0, 32'hFFFFFC01, pat(1),    "wrap_high_bits");

        // 6. Reset in the middle of a load
        loadWord(0, 32'hDEADBEEF, 0);
        applyStimulus(0, 8'h11, 0);
        applyStimulus(0, 8'h22, 0);
        readWord(0, 32'd0, NOP, "read_nop_while_busy");
        rst = 1'b0;
        expectAt(0, 1, 32'd0, "midreset_busy");
        expectAt(0, 3, 32'd0, "midreset_words");
        expectAt(0, 2, 32'd1, "midreset_ready");
        expectAt(0, 0, NOP,   "midreset_rom_data");
        idle(1);
        rst = 1'b1;
        readWord(0, 32'd0, 32'hDEADBEEF, "mem_retained_over_reset");
        readWord(0, 32'd1, pat(1),       "word1_not_written");
        loadWord(0, 32'h04030201, 1);
        idle(1);
        expectAt(0, 3, 32'd1, "words_after_reload");
        readWord(0, 32'd0, 32'h04030201, "reload_starts_at_0");

        // 5. Overflow on the 4-word instance
        for (int w = 1; w <= 5; w++) begin
            loadWord(1, {8{w[3:0]}}, w == 5);
        end
        idle(1);
        expectAt(0, 8, 32'd4, "ovf_words_saturate");
        expectAt(0, 9, 32'd1, "ovf_flag_set");
        readWord(1, 32'd0, 32'h11111111, "ovf_mem0");
        readWord(1, 32'd1, 32'h22222222, "ovf_mem1");
        readWord(1, 32'd2, 32'h33333333, "ovf_mem2");
        readWord(1, 32'd3, 32'h44444444, "ovf_mem3");
        readWord(1, 32'd4, 32'h11111111, "ovf_fifth_dropped");
        applyStimulus(1, 8'h77, 1);
        idle(1);
        expectAt(0, 9, 32'd0, "ovf_cleared_new_load");
        expectAt(0, 8, 32'd1, "words_new_load");
        readWord(1, 32'd0, 32'h00000077, "new_load_mem0");

        idle(3);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation never checked, required %h",
                     sb[0].name, sb[0].exp);
            sb.delete(0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
